// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: sequences 32-bit MEM-stage loads/stores onto a 16-bit
// asynchronous SRAM. Each word is split into a low and a high half access,
// and each half is held on the bus for WAIT_CYCLES cycles. While an access
// is in flight, freeze stalls the pipeline.
// Optional build macro SRAM_STALL_CNT_EN adds a saturating stall_cnt output.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 17;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_wr;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rd_data;
  logic [17:0]      r_sram_addr;
  logic [15:0]      r_sram_dq_out;
  logic             r_sram_dq_oe;
  logic             r_sram_we_n;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_is_wr_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [31:0]      w_wdata_nxt;
  logic [31:0]      w_rd_data_nxt;
  logic [17:0]      w_sram_addr_nxt;
  logic [15:0]      w_sram_dq_out_nxt;
  logic             w_sram_dq_oe_nxt;
  logic             w_sram_we_n_nxt;

  logic             w_req;
  logic             w_ready;
  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_addr_bits;

  // Request is masked during reset so the controller reports ready while held.
  assign w_req    = (mem_r_en | mem_w_en) & ~rst;
  assign w_offset = addr - 32'(ADDR_BASE);
  assign w_idx    = w_offset[18:2];
  assign w_unused_addr_bits = ^{w_offset[31:19], w_offset[1:0]};

  assign w_ready = ((r_state == S_IDLE) & ~w_req) | (r_state == S_DONE);
  assign ready   = w_ready;
  assign freeze  = ~w_ready;

  assign rd_data     = r_rd_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign sram_dq_oe  = r_sram_dq_oe;
  assign sram_we_n   = r_sram_we_n;

  // Next-state, datapath capture and next SRAM bus values.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_is_wr_nxt       = r_is_wr;
    w_idx_nxt         = r_idx;
    w_wdata_nxt       = r_wdata;
    w_rd_data_nxt     = r_rd_data;
    w_sram_addr_nxt   = r_sram_addr;
    w_sram_dq_out_nxt = r_sram_dq_out;
    w_sram_dq_oe_nxt  = 1'b0;
    w_sram_we_n_nxt   = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
          w_is_wr_nxt = mem_w_en;
          w_idx_nxt   = w_idx;
          w_wdata_nxt = wr_data;
        end
      end
      S_LO: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HI;
          if (!r_is_wr) begin
            w_rd_data_nxt[15:0] = sram_dq_in;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HI: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
          if (!r_is_wr) begin
            w_rd_data_nxt[31:16] = sram_dq_in;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        // The request visible here is the stale one; the pipeline advances now.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Bus is registered from the next state so it is glitch-free for the SRAM.
    if (w_state_nxt == S_LO) begin
      w_sram_addr_nxt  = {w_idx_nxt, 1'b0};
      w_sram_we_n_nxt  = ~w_is_wr_nxt;
      w_sram_dq_oe_nxt = w_is_wr_nxt;
      if (w_is_wr_nxt) begin
        w_sram_dq_out_nxt = w_wdata_nxt[15:0];
      end
    end else if (w_state_nxt == S_HI) begin
      w_sram_addr_nxt  = {w_idx_nxt, 1'b1};
      w_sram_we_n_nxt  = ~w_is_wr_nxt;
      w_sram_dq_oe_nxt = w_is_wr_nxt;
      if (w_is_wr_nxt) begin
        w_sram_dq_out_nxt = w_wdata_nxt[31:16];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_is_wr       <= 1'b0;
      r_idx         <= '0;
      r_wdata       <= '0;
      r_rd_data     <= '0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_is_wr       <= w_is_wr_nxt;
      r_idx         <= w_idx_nxt;
      r_wdata       <= w_wdata_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_sram_addr   <= w_sram_addr_nxt;
      r_sram_dq_out <= w_sram_dq_out_nxt;
      r_sram_dq_oe  <= w_sram_dq_oe_nxt;
      r_sram_we_n   <= w_sram_we_n_nxt;
    end
  end

`ifdef SRAM_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  // Saturating count of frozen cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (freeze && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: word-level reference memory, a small
// SRAM behavioural model, and a monitor that checks bus phases and results.
module tb_sram_mem_ctrl;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;
  localparam int unsigned NWRD = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wr_data, rd_data;
  logic        ready, freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
`ifdef SRAM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // External SRAM: half-word array, asynchronous read, write while we_n low.
  logic [15:0] sram_m [0:2*NWRD-1];
  assign sram_dq_in = sram_m[sram_addr[9:0]];
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_m[sram_addr[9:0]] <= sram_dq_out;
  end

  typedef struct {
    bit          wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } txn_t;

  txn_t        sbq[$];
  logic [31:0] ref_mem [0:NWRD-1];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  int          busy   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: checks each frozen cycle's bus against the queued access, and
  // the access length and rd_data when ready returns.
  txn_t mt;
  logic mhalf;
  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
    end else if (freeze) begin
      if (busy >= 1) begin
        if (sbq.size() == 0) begin
          chk("sb_has_txn", 32'd0, 32'd1);
        end else begin
          mt    = sbq[0];
          mhalf = (busy > int'(W));
          chk("sram_addr", {14'd0, sram_addr}, {14'd0, mt.idx, mhalf});
          chk("we_n", {31'd0, sram_we_n}, {31'd0, !mt.wr});
          chk("dq_oe", {31'd0, sram_dq_oe}, {31'd0, mt.wr});
          if (mt.wr)
            chk("dq_out", {16'd0, sram_dq_out},
                {16'd0, (mhalf ? mt.wdata[31:16] : mt.wdata[15:0])});
        end
      end
      busy++;
      if (busy > int'(1 + 2 * W)) chk("freeze_overrun", 32'(busy), 32'(1 + 2 * W));
    end else begin
      chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("idle_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      if (busy > 0) begin
        chk("freeze_len", 32'(busy), 32'(1 + 2 * W));
        if (sbq.size() == 0) begin
          chk("sb_has_txn", 32'd0, 32'd1);
        end else begin
          mt = sbq.pop_front();
          chk("rd_data", rd_data, mt.exp_rd);
        end
        busy = 0;
      end
    end
  end

  // Issue one access, hold it through the freeze, release after DONE.
  task automatic access(input bit r_en, input bit w_en, input int idx, input logic [31:0] d);
    txn_t t;
    int   n;
    t.wr    = w_en;
    t.idx   = 17'(idx);
    t.wdata = d;
    if (w_en) begin
      ref_mem[idx] = d;
    end else begin
      last_rd = ref_mem[idx];
    end
    t.exp_rd = last_rd;
    sbq.push_back(t);
    mem_r_en = r_en;
    mem_w_en = w_en;
    addr     = 32'(BASE) + 32'(idx) * 32'd4 + 32'($urandom_range(0, 3));
    wr_data  = d;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    txn_t t;
    bit   r, w;
    for (int i = 0; i < int'(2 * NWRD); i++) sram_m[i] = 16'($urandom);
    for (int i = 0; i < int'(NWRD); i++) ref_mem[i] = {sram_m[2*i+1], sram_m[2*i]};
    last_rd  = 32'd0;
    rst      = 1'b1;
    mem_r_en = 1'b1;
    mem_w_en = 1'b0;
    addr     = 32'(BASE);
    wr_data  = 32'd0;

    // Reset held with a pending read request.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_r_en = 1'b0;
    @(posedge clk);
    #1;

    // Directed: write, read back, rd_data held over a write, both enables.
    access(1'b0, 1'b1, 1, 32'hDEADBEEF);
    access(1'b1, 1'b0, 1, 32'h0);
    access(1'b0, 1'b1, 7, 32'hCAFEF00D);
    access(1'b1, 1'b1, 0, 32'h12345678);
    access(1'b1, 1'b0, 0, 32'h0);

    // Randomized accesses over a small index range to hit read-after-write.
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      access(r, w, int'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset during the high phase of a read aborts it.
    t.wr = 1'b0; t.idx = 17'd1; t.wdata = 32'd0; t.exp_rd = ref_mem[1];
    sbq.push_back(t);
    mem_r_en = 1'b1;
    addr     = 32'(BASE) + 32'd4;
    repeat (1 + W) @(posedge clk);
    #1;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    sbq.delete();
    last_rd  = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_rd_data", rd_data, 32'd0);
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    @(posedge clk);
    #1;

    // Two back-to-back reads after the abort complete normally.
    access(1'b1, 1'b0, 1, 32'h0);
    access(1'b1, 1'b0, 3, 32'h0);
`ifdef SRAM_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'(2 * (1 + 2 * W)));
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
